// File: rtl/axi_read_fetch.sv
// Read-side AXI4 master: splits a word-count request into INCR bursts that never
// cross a 4 KB boundary and buffers returned beats in a first-word-fall-through FIFO.
module axi_read_fetch #(
  parameter int FIFO_DEPTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] READ_ADDR,
  input  logic [15:0] READ_COUNT,
  input  logic        READ_REQ,
  output logic        READ_BUSY,
  output logic [31:0] READ_DATA,
  output logic        READ_VALID,
  input  logic        READ_READY,
  output logic        ERR,
  output logic [31:0] M_ARADDR,
  output logic [7:0]  M_ARLEN,
  output logic [2:0]  M_ARSIZE,
  output logic [1:0]  M_ARBURST,
  output logic        M_ARVALID,
  input  logic        M_ARREADY,
  input  logic [31:0] M_RDATA,
  input  logic [1:0]  M_RRESP,
  input  logic        M_RLAST,
  input  logic        M_RVALID,
  output logic        M_RREADY,
  output logic [1:0]  DBG_STATE
);

  // Every channel transfers on a clock edge where its valid and ready are both high;
  // a valid, once raised, holds with stable payload until that edge.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(FIFO_DEPTH);
  localparam logic [12:0] MAX_V   = 13'(MAX_BURST);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ADDR, S_DATA} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q;
  logic [15:0]   remaining_q;
  logic [12:0]   beats_q;
  logic [31:0]   ar_addr_q;
  logic [7:0]    ar_len_q;
  logic          err_q;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic [12:0]   to_boundary, limit, beats_calc;
  logic [AW:0]   free_slots;
  logic          room_ok, accept, ar_fire, push, pop;

  // Burst length: the smallest of what is left, the burst cap and the words up to the 4 KB edge.
  always_comb begin
    to_boundary = (13'h1000 - {1'b0, addr_q[11:0]}) >> 2;
    limit       = (MAX_V < to_boundary) ? MAX_V : to_boundary;
    beats_calc  = ({3'd0, limit} < remaining_q) ? limit : remaining_q[12:0];
  end

  assign free_slots = DEPTH_V - count_q;
  assign room_ok    = (32'(free_slots) >= 32'(beats_q));
  assign accept     = (state_q == S_IDLE) && READ_REQ && (READ_COUNT != 16'd0);
  assign ar_fire    = M_ARVALID && M_ARREADY;
  assign push       = M_RVALID && M_RREADY;
  assign pop        = READ_VALID && READ_READY;

  always_comb begin
    state_d   = state_q;
    M_ARVALID = 1'b0;
    M_RREADY  = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = S_CALC;
      S_CALC: state_d = S_ADDR;
      S_ADDR: begin
        // Free space only grows while waiting here, so ARVALID never drops before ARREADY.
        M_ARVALID = room_ok;
        if (room_ok && M_ARREADY) state_d = S_DATA;
      end
      S_DATA: begin
        M_RREADY = 1'b1;
        if (M_RVALID && M_RLAST) state_d = (remaining_q != 16'd0) ? S_CALC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'd0;
      remaining_q <= 16'd0;
      beats_q     <= 13'd0;
      ar_addr_q   <= 32'd0;
      ar_len_q    <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q      <= READ_ADDR & ~32'h3;
        remaining_q <= READ_COUNT;
        err_q       <= 1'b0;
      end
      if (state_q == S_CALC) begin
        beats_q   <= beats_calc;
        ar_addr_q <= addr_q;
        ar_len_q  <= 8'(beats_calc - 13'd1);
      end
      if (ar_fire) begin
        addr_q      <= addr_q + {17'd0, beats_q, 2'b00};
        remaining_q <= remaining_q - {3'd0, beats_q};
      end
      if (push && (M_RRESP != 2'b00)) err_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= M_RDATA;
  end

  assign READ_BUSY  = (state_q != S_IDLE);
  assign READ_VALID = (count_q != '0);
  assign READ_DATA  = mem[rd_ptr_q];
  assign ERR        = err_q;
  assign M_ARADDR   = ar_addr_q;
  assign M_ARLEN    = ar_len_q;
  assign M_ARSIZE   = 3'b010;
  assign M_ARBURST  = 2'b01;
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_axi_read_fetch.sv
// Self-checking bench for axi_read_fetch: reactive AXI slave, FIFO consumer and a
// burst/data reference model derived directly from the request arithmetic.
module tb_axi_read_fetch;

  localparam int FIFO_DEPTH = 32;
  localparam int MAX_BURST  = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] READ_ADDR = 32'd0;
  logic [15:0] READ_COUNT = 16'd0;
  logic        READ_REQ = 1'b0;
  logic        READ_BUSY;
  logic [31:0] READ_DATA;
  logic        READ_VALID;
  logic        READ_READY;
  logic        ERR;
  logic [31:0] M_ARADDR;
  logic [7:0]  M_ARLEN;
  logic [2:0]  M_ARSIZE;
  logic [1:0]  M_ARBURST;
  logic        M_ARVALID;
  logic        M_ARREADY;
  logic [31:0] M_RDATA;
  logic [1:0]  M_RRESP;
  logic        M_RLAST;
  logic        M_RVALID;
  logic        M_RREADY;
  logic [1:0]  dbg_state;

  axi_read_fetch #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .CLK(CLK), .RST(RST),
    .READ_ADDR(READ_ADDR), .READ_COUNT(READ_COUNT), .READ_REQ(READ_REQ),
    .READ_BUSY(READ_BUSY), .READ_DATA(READ_DATA), .READ_VALID(READ_VALID),
    .READ_READY(READ_READY), .ERR(ERR),
    .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST), .M_RVALID(M_RVALID),
    .M_RREADY(M_RREADY), .DBG_STATE(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- bench state ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [39:0] ar_log[$];
  logic [39:0] exp_ar_q[$];
  int rr_mode = 1;
  bit stall_mode = 1'b0;
  int err_beat = -1;
  int beat_cnt = 0;
  int occ = 0;
  int last_rlast_cyc = -1;

  bit          burst_active = 1'b0;
  logic [31:0] b_addr = 32'd0;
  int          b_left = 0;
  bit          pend_ar = 1'b0, pend_r = 1'b0, pend_pop = 1'b0, pend_rlast = 1'b0;
  logic [39:0] pend_ar_val = 40'd0;
  logic [31:0] pend_pop_data = 32'd0;
  bit          ar_hold = 1'b0;
  logic [39:0] ar_hold_val = 40'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'hC3A5_1E0F;
  endfunction

  // Reference model: expected word stream and burst list for one request.
  task automatic build_model(input logic [31:0] addr, input int count);
    logic [31:0] a;
    int rem, room, b;
    exp_q.delete();
    exp_ar_q.delete();
    a = addr & ~32'h3;
    for (int i = 0; i < count; i++) exp_q.push_back(mem_word(a + 32'(4 * i)));
    rem = count;
    while (rem > 0) begin
      room = (4096 - int'(a % 32'd4096)) / 4;
      b = rem;
      if (b > MAX_BURST) b = MAX_BURST;
      if (b > room) b = room;
      exp_ar_q.push_back({a, 8'(b - 1)});
      a = a + 32'(4 * b);
      rem -= b;
    end
  endtask

  // ---------------- AXI slave, consumer and protocol monitor ----------------
  initial begin
    M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = 32'd0; M_RRESP = 2'b00; M_RLAST = 1'b0;
    READ_READY = 1'b0;
    forever begin
      @(posedge CLK); #1;
      cyc++;
      if (RST) begin
        burst_active = 1'b0; pend_ar = 1'b0; pend_r = 1'b0; pend_pop = 1'b0; ar_hold = 1'b0;
        occ = 0;
        M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RLAST = 1'b0; M_RRESP = 2'b00; READ_READY = 1'b0;
      end else begin
        if (pend_r) begin
          occ++;
          beat_cnt++;
          checks++;
          if (occ > FIFO_DEPTH) begin
            failures++;
            $display("FAIL fifo_overflow occupancy=%0d depth=%0d", occ, FIFO_DEPTH);
          end
          if (pend_rlast) last_rlast_cyc = cyc;
          b_addr += 32'd4;
          b_left--;
          if (b_left == 0) burst_active = 1'b0;
        end
        if (pend_ar) begin
          ar_log.push_back(pend_ar_val);
          b_addr = pend_ar_val[39:8];
          b_left = int'(pend_ar_val[7:0]) + 1;
          burst_active = 1'b1;
        end
        if (pend_pop) begin
          got_q.push_back(pend_pop_data);
          occ--;
        end

        checks++;
        if (READ_VALID !== (occ != 0)) begin
          failures++;
          $display("FAIL read_valid got=%b exp=%b cyc=%0d", READ_VALID, (occ != 0), cyc);
        end
        if (ar_hold) begin
          checks++;
          if (M_ARVALID !== 1'b1 || {M_ARADDR, M_ARLEN} !== ar_hold_val) begin
            failures++;
            $display("FAIL ar_stable got=%b/%h exp=1/%h", M_ARVALID, {M_ARADDR, M_ARLEN}, ar_hold_val);
          end
        end
        if (M_ARVALID === 1'b1) begin
          checks++;
          if (burst_active) begin
            failures++;
            $display("FAIL ar_outstanding got=AR_during_burst exp=no_AR cyc=%0d", cyc);
          end
          checks++;
          if (FIFO_DEPTH - occ < int'(M_ARLEN) + 1) begin
            failures++;
            $display("FAIL ar_space free=%0d beats=%0d", FIFO_DEPTH - occ, int'(M_ARLEN) + 1);
          end
        end

        M_ARREADY = stall_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
        if (burst_active && (!stall_mode || $urandom_range(0, 2) != 0)) begin
          M_RVALID = 1'b1;
          M_RDATA  = mem_word(b_addr);
          M_RLAST  = (b_left == 1);
          M_RRESP  = (beat_cnt == err_beat) ? 2'b10 : 2'b00;
        end else begin
          M_RVALID = 1'b0;
          M_RLAST  = 1'b0;
          M_RRESP  = 2'b00;
        end
        READ_READY = (rr_mode == 2) ? ($urandom_range(0, 1) == 1) : (rr_mode == 1);

        pend_ar       = M_ARVALID && M_ARREADY;
        pend_ar_val   = {M_ARADDR, M_ARLEN};
        pend_r        = M_RVALID && M_RREADY;
        pend_rlast    = M_RLAST;
        pend_pop      = READ_VALID && READ_READY;
        pend_pop_data = READ_DATA;
        ar_hold       = M_ARVALID && !M_ARREADY;
        ar_hold_val   = {M_ARADDR, M_ARLEN};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_run();
    got_q.delete();
    ar_log.delete();
    beat_cnt = 0;
  endtask

  task automatic start_req(input logic [31:0] addr, input logic [15:0] count);
    @(negedge CLK);
    READ_ADDR = addr; READ_COUNT = count; READ_REQ = 1'b1;
    @(negedge CLK);
    READ_REQ = 1'b0;
  endtask

  task automatic wait_done(input int n, output bit ok, output int fall_cyc);
    ok = 1'b0;
    fall_cyc = -1;
    for (int i = 0; i < 5000; i++) begin
      if (!READ_BUSY && fall_cyc < 0) fall_cyc = cyc;
      if (!READ_BUSY && got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({READ_BUSY, READ_VALID, M_ARVALID, M_RREADY, ERR} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {READ_BUSY, READ_VALID, M_ARVALID, M_RREADY, ERR});
    end
    checks++;
    if ({M_ARADDR, M_ARLEN} !== 40'd0) begin
      failures++;
      $display("FAIL reset_ar got=%h exp=0", {M_ARADDR, M_ARLEN});
    end
    checks++;
    if (M_ARSIZE !== 3'b010 || M_ARBURST !== 2'b01) begin
      failures++;
      $display("FAIL ar_const got=%b/%b exp=010/01", M_ARSIZE, M_ARBURST);
    end
    RST = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    int fall;
    rr_mode = 1; stall_mode = 1'b0; err_beat = -1;
    clear_run();
    build_model(32'h1000_0000, 8);
    start_req(32'h1000_0000, 16'd8);
    checks++;
    if (READ_BUSY !== 1'b1) begin failures++; $display("FAIL basic_busy_rise got=%b exp=1", READ_BUSY); end
    wait_done(8, ok, fall);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout got=%0d words exp=8", got_q.size()); end
    checks++;
    if (ar_log.size() != 1 || ar_log[0] !== {32'h1000_0000, 8'd7}) begin
      failures++;
      $display("FAIL basic_ar got=%0d bursts first=%h exp=1 first=%h", ar_log.size(),
               (ar_log.size() > 0) ? ar_log[0] : 40'd0, {32'h1000_0000, 8'd7});
    end
    checks++;
    if (fall != last_rlast_cyc) begin
      failures++;
      $display("FAIL basic_busy_fall got=cyc%0d exp=cyc%0d", fall, last_rlast_cyc);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL basic_words got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (ERR !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", ERR); end
  endtask

  task automatic test_split_and_boundary();
    bit ok;
    int fall;
    logic [39:0] want[$];
    rr_mode = 1; stall_mode = 1'b0; err_beat = -1;
    // 40 aligned words: three bursts
    clear_run();
    build_model(32'h2000_0000, 40);
    start_req(32'h2000_0000, 16'd40);
    wait_done(40, ok, fall);
    want = '{{32'h2000_0000, 8'd15}, {32'h2000_0040, 8'd15}, {32'h2000_0080, 8'd7}};
    checks++;
    if (!ok || ar_log.size() != 3) begin failures++; $display("FAIL split_bursts got=%0d ok=%0d exp=3", ar_log.size(), ok); end
    for (int i = 0; i < 3 && i < ar_log.size(); i++) begin
      checks++;
      if (ar_log[i] !== want[i]) begin failures++; $display("FAIL split_ar[%0d] got=%h exp=%h", i, ar_log[i], want[i]); end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL split_words got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL split_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    // 6 words straddling the 4 KB edge
    clear_run();
    build_model(32'h0000_0FF8, 6);
    start_req(32'h0000_0FF8, 16'd6);
    wait_done(6, ok, fall);
    want = '{{32'h0000_0FF8, 8'd1}, {32'h0000_1000, 8'd3}};
    checks++;
    if (!ok || ar_log.size() != 2) begin failures++; $display("FAIL boundary_bursts got=%0d ok=%0d exp=2", ar_log.size(), ok); end
    for (int i = 0; i < 2 && i < ar_log.size(); i++) begin
      checks++;
      if (ar_log[i] !== want[i]) begin failures++; $display("FAIL boundary_ar[%0d] got=%h exp=%h", i, ar_log[i], want[i]); end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL boundary_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int fall;
    rr_mode = 0; stall_mode = 1'b0; err_beat = -1;
    clear_run();
    build_model(32'h3000_0000, 64);
    start_req(32'h3000_0000, 16'd64);
    repeat (100) @(negedge CLK);
    checks++;
    if (occ != FIFO_DEPTH || ar_log.size() != 2 || M_ARVALID !== 1'b0) begin
      failures++;
      $display("FAIL bp_hold got=occ%0d/ar%0d/arvalid%b exp=occ%0d/ar2/arvalid0", occ, ar_log.size(), M_ARVALID, FIFO_DEPTH);
    end
    rr_mode = 1;
    wait_done(64, ok, fall);
    checks++;
    if (!ok || ar_log.size() != exp_ar_q.size()) begin
      failures++;
      $display("FAIL bp_bursts got=%0d ok=%0d exp=%0d", ar_log.size(), ok, exp_ar_q.size());
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_words got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall_error();
    bit ok;
    int fall, n;
    logic [31:0] a;
    rr_mode = 2; stall_mode = 1'b1; err_beat = 5;
    clear_run();
    a = $urandom;
    a[11:8] = 4'hF;
    n = $urandom_range(20, 60);
    build_model(a, n);
    start_req(a, 16'(n));
    wait_done(n, ok, fall);
    checks++;
    if (!ok || ar_log.size() != exp_ar_q.size()) begin failures++; $display("FAIL stall_bursts got=%0d ok=%0d exp=%0d", ar_log.size(), ok, exp_ar_q.size()); end
    for (int i = 0; i < exp_ar_q.size() && i < ar_log.size(); i++) begin
      checks++;
      if (ar_log[i] !== exp_ar_q[i]) begin failures++; $display("FAIL stall_ar[%0d] got=%h exp=%h", i, ar_log[i], exp_ar_q[i]); end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    repeat (5) @(negedge CLK);
    checks++;
    if (ERR !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", ERR); end
    // next accepted request clears ERR
    rr_mode = 1; stall_mode = 1'b0; err_beat = -1;
    clear_run();
    build_model(32'h0000_0100, 4);
    start_req(32'h0000_0100, 16'd4);
    checks++;
    if (ERR !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", ERR); end
    wait_done(4, ok, fall);
    checks++;
    if (!ok || got_q.size() != 4 || ERR !== 1'b0) begin
      failures++;
      $display("FAIL err_clear_run got=%0d words err=%b exp=4 words err=0", got_q.size(), ERR);
    end
  endtask

  task automatic test_random();
    bit ok;
    int fall, n;
    logic [31:0] a;
    for (int t = 0; t < 5; t++) begin
      rr_mode = 2; stall_mode = 1'($urandom_range(0, 1)); err_beat = -1;
      clear_run();
      a = $urandom;
      n = $urandom_range(1, 70);
      build_model(a, n);
      start_req(a, 16'(n));
      wait_done(n, ok, fall);
      checks++;
      if (!ok || ar_log.size() != exp_ar_q.size()) begin failures++; $display("FAIL rand%0d_bursts got=%0d ok=%0d exp=%0d", t, ar_log.size(), ok, exp_ar_q.size()); end
      for (int i = 0; i < exp_ar_q.size() && i < ar_log.size(); i++) begin
        checks++;
        if (ar_log[i] !== exp_ar_q[i]) begin failures++; $display("FAIL rand%0d_ar[%0d] got=%h exp=%h", t, i, ar_log[i], exp_ar_q[i]); end
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_words got=%0d exp=%0d", t, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_data[%0d] got=%h exp=%h", t, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_edge_cases();
    bit ok;
    int fall;
    rr_mode = 1; stall_mode = 1'b0; err_beat = -1;
    // zero count is ignored
    clear_run();
    start_req(32'h1234_5678, 16'd0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (READ_BUSY !== 1'b0 || M_ARVALID !== 1'b0) begin
        failures++;
        $display("FAIL count0 got=busy%b/arvalid%b exp=0/0", READ_BUSY, M_ARVALID);
      end
      @(negedge CLK);
    end
    checks++;
    if (ar_log.size() != 0) begin failures++; $display("FAIL count0_ar got=%0d exp=0", ar_log.size()); end
    // request while busy is ignored
    clear_run();
    build_model(32'h4000_0100, 40);
    start_req(32'h4000_0100, 16'd40);
    repeat (10) @(negedge CLK);
    start_req(32'h5000_0000, 16'd5);
    wait_done(40, ok, fall);
    repeat (5) @(negedge CLK);
    checks++;
    if (!ok || ar_log.size() != exp_ar_q.size() || got_q.size() != 40) begin
      failures++;
      $display("FAIL busy_req got=%0d bursts %0d words exp=%0d bursts 40 words", ar_log.size(), got_q.size(), exp_ar_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL busy_req_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int fall;
    rr_mode = 0; stall_mode = 1'b0; err_beat = 2;
    clear_run();
    start_req(32'h6000_0000, 16'd40);
    for (int i = 0; i < 500 && beat_cnt < 6; i++) @(negedge CLK);
    checks++;
    if (beat_cnt < 6 || READ_VALID !== 1'b1 || ERR !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_setup got=beats%0d/valid%b/err%b exp=beats6/valid1/err1", beat_cnt, READ_VALID, ERR);
    end
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({READ_BUSY, READ_VALID, M_ARVALID, M_RREADY, ERR} !== 5'b0 || {M_ARADDR, M_ARLEN} !== 40'd0) begin
      failures++;
      $display("FAIL rst_mid got=%b/%h exp=00000/0", {READ_BUSY, READ_VALID, M_ARVALID, M_RREADY, ERR}, {M_ARADDR, M_ARLEN});
    end
    RST = 1'b0;
    rr_mode = 1; err_beat = -1;
    clear_run();
    build_model(32'h7000_0FC0, 20);
    start_req(32'h7000_0FC0, 16'd20);
    wait_done(20, ok, fall);
    checks++;
    if (!ok || ar_log.size() != exp_ar_q.size() || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rst_recover got=%0d bursts %0d words exp=%0d bursts %0d words", ar_log.size(), got_q.size(), exp_ar_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rst_recover_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_split_and_boundary();
    test_backpressure();
    test_stall_error();
    test_random();
    test_edge_cases();
    test_reset_mid();
    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_read_fetch.md
Name: axi_read_fetch

Overview:
- Read-side AXI4 master that feeds the bitstream wrapper's READ_* FIFO interface.
- Accepts one word-count read request (address, count) and splits it into AXI4 INCR bursts. Bursts never cross a 4 KB boundary.
- Buffers returned beats in a first-word-fall-through FIFO that the wrapper drains with a valid/ready handshake.
- Sits between the AXI_CTRL/wrapper pair and the HP/ACP AXI port.

Parameters:
- FIFO_DEPTH, 32, data FIFO depth in 32-bit words; power of two, at least MAX_BURST.
- MAX_BURST, 16, maximum beats per AXI burst; range 1..256.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- READ_ADDR  in  32  byte start address; bits [1:0] are ignored (treated as 0).
- READ_COUNT  in  16  number of 32-bit words to fetch.
- READ_REQ  in  1  start pulse; sampled only in IDLE.
- READ_BUSY  out  1  request in progress.
- READ_DATA  out  32  FIFO head word.
- READ_VALID  out  1  FIFO non-empty.
- READ_READY  in  1  consumer pops the head when READ_VALID && READ_READY.
- ERR  out  1  sticky: some beat returned RRESP != OKAY.
- M_ARADDR  out  32  burst address.
- M_ARLEN  out  8  beats-1.
- M_ARSIZE  out  3  constant 3'b010.
- M_ARBURST  out  2  constant 2'b01 (INCR).
- M_ARVALID  out  1  address valid.
- M_ARREADY  in  1  address accepted.
- M_RDATA  in  32  read data.
- M_RRESP  in  2  read response.
- M_RLAST  in  1  last beat of burst.
- M_RVALID  in  1  data valid.
- M_RREADY  out  1  data ready.

Behaviour:
- Reset (RST high at a CLK edge):
  - State returns to IDLE and the FIFO is emptied.
  - READ_BUSY=0, READ_VALID=0, M_ARVALID=0, M_RREADY=0, ERR=0, M_ARADDR=0, M_ARLEN=0.
  - Reset mid-burst drops any outstanding beats. The bench must reset the AXI slave in the same cycle.
- FSM states: IDLE, CALC, ADDR, DATA.
- IDLE:
  - If READ_REQ=1 and READ_COUNT!=0: latch addr (bits [1:0] forced 0) and remaining=READ_COUNT, clear ERR, go to CALC.
  - READ_BUSY rises on the next cycle.
  - If READ_COUNT=0: the request is ignored and READ_BUSY stays 0.
- CALC (1 cycle): compute beats = min(remaining, MAX_BURST, (4096 - addr[11:0])/4). Go to ADDR.
- ADDR:
  - Hold M_ARVALID=0 until free slots >= beats. Free slots = FIFO_DEPTH - occupancy.
  - Then drive M_ARADDR=addr, M_ARLEN=beats-1, M_ARVALID=1.
  - Once asserted, M_ARVALID and all AR fields stay stable until M_ARREADY.
  - On the handshake: addr += beats*4, remaining -= beats, go to DATA.
- DATA:
  - M_RREADY=1 for the whole state. The space reservation in ADDR guarantees the FIFO cannot overflow.
  - Each beat with M_RVALID&&M_RREADY is pushed into the FIFO.
  - If M_RRESP != 2'b00, set ERR. The beat is still pushed.
  - On the beat with M_RLAST=1: go to CALC if remaining!=0, else go to IDLE.
- Outstanding traffic: exactly one burst outstanding at a time. A new AR is never issued before the previous RLAST.
- READ_BUSY:
  - High from the cycle after an accepted REQ until the cycle after the final RLAST beat is pushed.
  - It does not wait for the FIFO to drain.
- FIFO:
  - First-word-fall-through: a beat pushed at edge N is on READ_DATA with READ_VALID=1 after edge N (1-cycle latency).
  - Simultaneous push and pop in the same cycle leaves the occupancy unchanged; the order is preserved.
  - The FIFO never overflows. A pop when empty has no effect.
- READ_REQ outside IDLE is ignored. No queuing.
- Widths:
  - All address arithmetic is mod 2^32.
  - beats and the 4 KB limit use 13-bit intermediates.
  - remaining is 16 bits.

Test Plan:
- Basic fetch: ADDR=0x1000_0000, COUNT=8, READ_READY=1, slave with zero wait states → single AR (ARADDR=0x1000_0000, ARLEN=7); 8 words out in order; READ_BUSY low 1 cycle after RLAST; ERR=0.
- Burst splitting: COUNT=40, MAX_BURST=16, aligned address → ARLEN sequence 15,15,7; addresses +0x00, +0x40, +0x80; 40 words delivered in order.
- 4 KB boundary: ADDR=0x0000_0FF8, COUNT=6 → two bursts: ARADDR=0xFF8 with ARLEN=1, then ARADDR=0x1000 with ARLEN=3.
- Backpressure: COUNT=64, FIFO_DEPTH=32, READ_READY=0 for the first 100 cycles → M_ARVALID stays low once FIFO free < 16; no data is lost; all 64 words arrive after READ_READY=1.
- Slave stalls and error: random ARREADY/RVALID gaps; one beat returns RRESP=2'b10 → AR fields stable while ARVALID is high; ERR=1 sticky until the next accepted REQ; data is still delivered.
- Edge cases:
  - COUNT=0 → no AR and READ_BUSY=0.
  - REQ pulsed while busy → ignored.
  - RST asserted mid-DATA → all outputs return to reset values on the next edge; a new request then completes normally.
